// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and word-only data-memory signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a word-only data memory; sub-word stores
// are read-modify-write, loads are sign/zero-extended, bad requests rejected.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_LOAD   | word read, lane extracted at the edge
// S_RMW_RD | sub-word store: capture the old word
// S_RMW_WR | sub-word store: write merged word
// S_SW_WR  | full-word store write
// S_RESP   | one-cycle response pulse
module load_store_unit #(
    parameter int DEPTH = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RMW_RD, S_RMW_WR, S_SW_WR, S_RESP
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      r_state, w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_word;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    logic        w_accept, w_illegal, w_misalign, w_range, w_error;
    logic [31:0] w_word_idx, w_load_data, w_merged;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_illegal  = bus.req_write ? (bus.req_funct3 >= 3'd3)
                                      : (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6);
    assign w_misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign w_range    = {2'b00, bus.req_addr[31:2]} >= DEPTH_W;
    assign w_error    = w_illegal || w_misalign || w_range;
    assign w_word_idx = {2'b00, r_addr[31:2]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_error)                          w_next = S_RESP;
                    else if (!bus.req_write)              w_next = S_LOAD;
                    else if (bus.req_funct3[1:0] == 2'b10) w_next = S_SW_WR;
                    else                                  w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_SW_WR:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_address      = '0;
        bus.mem_write_data   = '0;
        case (r_state)
            S_IDLE:           bus.req_ready = 1'b1;
            S_LOAD, S_RMW_RD: bus.mem_address = w_word_idx;
            S_RMW_WR: begin
                bus.mem_address      = w_word_idx;
                bus.mem_write_enable = 1'b1;
                bus.mem_write_data   = w_merged;
            end
            S_SW_WR: begin
                bus.mem_address      = w_word_idx;
                bus.mem_write_enable = 1'b1;
                bus.mem_write_data   = r_wdata;
            end
            S_RESP:           bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;

    always_comb begin
        w_byte = bus.mem_read_data[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = bus.mem_read_data[15:8];
            2'd2:    w_byte = bus.mem_read_data[23:16];
            2'd3:    w_byte = bus.mem_read_data[31:24];
            default: w_byte = bus.mem_read_data[7:0];
        endcase
        w_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        // funct3[2] set means unsigned (LBU/LHU)
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load_data = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
                default: ;
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // Response registers only change on the transition into S_RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_word       <= '0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_funct3 <= bus.req_funct3;
                        if (w_error) begin
                            r_resp_rdata <= '0;
                            r_resp_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_error <= 1'b0;
                end
                S_RMW_RD: r_word <= bus.mem_read_data;
                S_RMW_WR, S_SW_WR: begin
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// against a byte-level reference memory model.
module tb_load_store_unit;
    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if bus ();
    load_store_unit #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          we_count = 0;
    logic [31:0] we_addr  = '0;

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            we_count <= we_count + 1;
            we_addr  <= bus.mem_address;
            if (bus.mem_address < DEPTH) mem[bus.mem_address[9:0]] <= bus.mem_write_data;
        end
    end

    always_comb begin
        if (bus.mem_write_enable || bus.mem_address >= DEPTH) bus.mem_read_data = '0;
        else                                                  bus.mem_read_data = mem[bus.mem_address[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"},        32'(bus.req_ready), 32'd1);
        chk({tag, " resp_valid"},       32'(bus.resp_valid), 32'd0);
        chk({tag, " resp_error"},       32'(bus.resp_error), 32'd0);
        chk({tag, " mem_write_enable"}, 32'(bus.mem_write_enable), 32'd0);
        chk({tag, " resp_rdata"},       bus.resp_rdata, 32'd0);
        chk({tag, " mem_address"},      bus.mem_address, 32'd0);
        chk({tag, " mem_write_data"},   bus.mem_write_data, 32'd0);
    endtask

    // Reference: access size from funct3, byte lanes by address modulo 4.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output int lat);
        longint a, word, val, mask;
        int size, sh;
        logic [31:0] widx;
        a    = longint'(addr);
        widx = addr >> 2;
        sh   = 8 * int'(a % 4);
        size = 0;
        if (wr) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
        end
        err = 1'b0;
        if (size == 0) err = 1'b1;
        else if (a % size != 0) err = 1'b1;
        else if (widx >= DEPTH) err = 1'b1;
        rd  = '0;
        lat = 1;
        if (err) return;
        word = longint'(ref_mem[widx[9:0]]);
        mask = (longint'(1) << (8 * size)) - 1;
        if (!wr) begin
            val = (word >> sh) & mask;
            if (f3 < 3'd4 && size < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
            rd  = val[31:0];
            lat = 2;
        end else begin
            word = (word & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
            ref_mem[widx[9:0]] = word[31:0];
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        bit          e_err;
        logic [31:0] e_rd, g_rd, widx;
        logic        g_err;
        int          e_lat, lat, n_resp, we0;
        model(wr, f3, addr, wd, e_err, e_rd, e_lat);
        widx = addr >> 2;
        @(negedge clk);
        chk({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        we0    = we_count;
        lat    = 0;
        n_resp = 0;
        g_rd   = '0;
        g_err  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, " ready_busy"}, 32'(bus.req_ready), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.resp_valid) begin
                n_resp++;
                if (lat == 0) begin
                    lat   = c;
                    g_rd  = bus.resp_rdata;
                    g_err = bus.resp_error;
                end
            end
        end
        chk({tag, " resp_count"}, 32'(n_resp), 32'd1);
        chk({tag, " latency"},    32'(lat), 32'(e_lat));
        chk({tag, " resp_error"}, 32'(g_err), 32'(e_err));
        chk({tag, " resp_rdata"}, g_rd, e_rd);
        chk({tag, " rdata_hold"}, bus.resp_rdata, e_rd);
        chk({tag, " we_pulses"},  32'(we_count - we0), (wr && !e_err) ? 32'd1 : 32'd0);
        if (wr && !e_err) chk({tag, " we_addr"}, we_addr, widx);
        if (widx < DEPTH) chk({tag, " mem_word"}, mem[widx[9:0]], ref_mem[widx[9:0]]);
    endtask

    task automatic b2b(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
        bit          e_err;
        logic [31:0] e_rd, widx;
        int          e_lat, p, we0, bad_ready, bad_resp;
        model(wr, f3, addr, wd, e_err, e_rd, e_lat);
        widx      = addr >> 2;
        p         = e_lat + 1;
        bad_ready = 0;
        bad_resp  = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        we0 = we_count;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.req_ready !== ((k % p) == 0)) bad_ready++;
            if (bus.resp_valid !== ((k % p) == e_lat)) bad_resp++;
            if (bus.resp_valid && bus.resp_rdata !== e_rd) bad_resp++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, " ready_pattern"}, 32'(bad_ready), 32'd0);
        chk({tag, " resp_pattern"},  32'(bad_resp), 32'd0);
        chk({tag, " we_pulses"}, 32'(we_count - we0), wr ? 32'((12 + p - 1) / p) : 32'd0);
        chk({tag, " mem_word"}, mem[widx[9:0]], ref_mem[widx[9:0]]);
    endtask

    initial begin
        int we0, n_resp, r;
        bit wr;
        logic [2:0]  f3;
        logic [31:0] addr;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int w = 0; w < 16; w++) do_req(1'b1, 3'd2, 32'(w * 4), $urandom, "init_sw");

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
        do_req(1'b1, 3'd0, 32'h11, 32'h55, "sb_11");
        do_req(1'b1, 3'd1, 32'h12, 32'h1234, "sh_12");
        chk("rmw_word", mem[4], 32'h123455EF);

        do_req(1'b1, 3'd2, 32'h10, 32'h80FF7F01, "sw_pattern");
        do_req(1'b0, 3'd0, 32'h12, 32'h0, "lb_12");
        do_req(1'b0, 3'd4, 32'h12, 32'h0, "lbu_12");
        do_req(1'b0, 3'd0, 32'h11, 32'h0, "lb_11");
        do_req(1'b0, 3'd1, 32'h12, 32'h0, "lh_12");
        do_req(1'b0, 3'd5, 32'h12, 32'h0, "lhu_12");

        do_req(1'b0, 3'd2, 32'h13, 32'h0, "err_lw_13");
        do_req(1'b1, 3'd1, 32'h11, 32'hAAAA, "err_sh_11");
        do_req(1'b0, 3'd3, 32'h10, 32'h0, "err_f3_011");
        do_req(1'b1, 3'd2, 32'(4 * DEPTH), 32'h12345678, "err_range");
        chk("err_word4", mem[4], 32'h80FF7F01);

        b2b(1'b0, 3'd2, 32'h10, 32'h0, "b2b_lw");
        b2b(1'b1, 3'd0, 32'h11, 32'hC3, "b2b_sb");

        // Abort an SB in its write cycle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h11;
        bus.req_wdata  = 32'h0000005A;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort in_rmw_wr", 32'(bus.mem_write_enable), 32'd1);
        we0 = we_count;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        #1 rst_n = 1'b1;
        n_resp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid) n_resp++;
        end
        chk("abort resp_count", 32'(n_resp), 32'd0);
        chk("abort we_pulses", 32'(we_count - we0), 32'd0);
        chk("abort word4", mem[4], ref_mem[4]);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "after_abort_lw");

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
            else if (r == 1) addr = $urandom;
            else             addr = 32'($urandom_range(0, 63));
            do_req(wr, f3, addr, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
